// File: rtl/jump_branch_ras_if.sv
// Valid/ready bundle between decode and the control-transfer resolver.
// master drives instructions in and accepts results; slave is the unit.
interface jump_branch_ras_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
);
  localparam int DW = $clog2(RAS_DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      rs_idx;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [25:0]     jump_target;
  logic [15:0]     imm16;
  logic            out_valid;
  logic            out_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            link_enable;
  logic [4:0]      link_reg;
  logic [XLEN-1:0] link_address;
  logic            ras_mispredict;
  logic [DW-1:0]   ras_depth;

  modport master (
    output in_valid, pc, opcode, funct, rs_idx, rd_idx,
    output rs_data, rt_data, jump_target, imm16, out_ready,
    input  in_ready, out_valid, redirect, redirect_addr,
    input  link_enable, link_reg, link_address,
    input  ras_mispredict, ras_depth
  );

  modport slave (
    input  in_valid, pc, opcode, funct, rs_idx, rd_idx,
    input  rs_data, rt_data, jump_target, imm16, out_ready,
    output in_ready, out_valid, redirect, redirect_addr,
    output link_enable, link_reg, link_address,
    output ras_mispredict, ras_depth
  );
endinterface

// File: rtl/jump_branch_ras_unit.sv
// Registered j/jal/jr/jalr/beq/bne resolver with a circular return-address stack.
// Define JUMP_BRANCH_RAS_PERF_EN to add redirect/mispredict counters.
module jump_branch_ras_unit #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  parameter int PC_STEP   = 4
) (
  input logic clk,
  input logic rst,
  jump_branch_ras_if.slave bus
`ifdef JUMP_BRANCH_RAS_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_mispredicts
`endif
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic            valid_q;
  logic            redir_q;
  logic [XLEN-1:0] addr_q;
  logic            len_q;
  logic [4:0]      lreg_q;
  logic [XLEN-1:0] laddr_q;
  logic            mis_q;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   wr_idx;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] stack [RAS_DEPTH];

  logic            accept;
  logic            is_r, is_j, is_jal, is_beq, is_bne;
  logic            is_jr, is_jalr;
  logic            rs_ra, rd_ra;
  logic            push, pop, empty, hit;
  logic            wr_en;
  logic            eq;
  logic            taken;
  logic            link_en;
  logic            mispred;
  logic [4:0]      lreg;
  logic [XLEN-1:0] pc4, jtgt, btgt, tgt, top;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign is_r    = bus.opcode == 6'h00;
  assign is_j    = bus.opcode == 6'h02;
  assign is_jal  = bus.opcode == 6'h03;
  assign is_beq  = bus.opcode == 6'h04;
  assign is_bne  = bus.opcode == 6'h05;
  assign is_jr   = is_r && bus.funct == 6'h08;
  assign is_jalr = is_r && bus.funct == 6'h09;

  assign pc4  = bus.pc + XLEN'(PC_STEP);
  assign jtgt = {pc4[XLEN-1:28], bus.jump_target, 2'b00};
  assign btgt = pc4 + ({{(XLEN-16){bus.imm16[15]}}, bus.imm16} << 2);
  assign eq   = bus.rs_data == bus.rt_data;

  always_comb begin
    taken = 1'b0;
    tgt   = pc4;
    unique case (1'b1)
      is_j, is_jal: begin
        taken = 1'b1;
        tgt   = jtgt;
      end
      is_jr, is_jalr: begin
        taken = 1'b1;
        tgt   = bus.rs_data;
      end
      is_beq: begin
        taken = eq;
        tgt   = eq ? btgt : pc4;
      end
      is_bne: begin
        taken = !eq;
        tgt   = eq ? pc4 : btgt;
      end
      default: ;
    endcase
  end

  assign rs_ra   = bus.rs_idx == 5'd31;
  assign rd_ra   = bus.rd_idx == 5'd31;
  assign link_en = is_jal || is_jalr;
  assign lreg    = is_jal ? 5'd31 : (is_jalr ? bus.rd_idx : 5'd0);

  // jalr $ra,$ra is a coroutine swap: pop-and-push onto the same slot
  assign push  = is_jal || (is_jalr && rd_ra);
  assign pop   = (is_jr && rs_ra) || (is_jalr && rs_ra && rd_ra);
  assign empty = count == '0;
  assign hit   = pop && !empty;
  assign top   = stack[ptr];

  assign mispred = pop && (empty || top != bus.rs_data);
  assign ptr_inc = ptr + 1'b1;
  assign wr_idx  = hit ? ptr : ptr_inc;
  assign wr_en   = accept && push;

  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_idx] <= pc4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      redir_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= 1'b0;
      lreg_q  <= '0;
      laddr_q <= '0;
      mis_q   <= 1'b0;
      ptr     <= '0;
      count   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      redir_q <= taken;
      addr_q  <= tgt;
      len_q   <= link_en;
      lreg_q  <= lreg;
      laddr_q <= pc4;
      mis_q   <= mispred;
      if (push && !hit) begin
        ptr <= ptr_inc;
        if (count != FULL) count <= count + 1'b1;
      end else if (hit && !push) begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef JUMP_BRANCH_RAS_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects   <= '0;
      perf_mispredicts <= '0;
    end else if (accept) begin
      perf_redirects   <= perf_redirects + {31'd0, taken};
      perf_mispredicts <= perf_mispredicts + {31'd0, mispred};
    end
  end
`endif

  assign bus.out_valid      = valid_q;
  assign bus.redirect       = redir_q;
  assign bus.redirect_addr  = addr_q;
  assign bus.link_enable    = len_q;
  assign bus.link_reg       = lreg_q;
  assign bus.link_address   = laddr_q;
  assign bus.ras_mispredict = mis_q;
  assign bus.ras_depth      = count;

endmodule

// File: tb/tb_jump_branch_ras_unit.sv
// Directed and randomized checks of jump_branch_ras_unit against a
// queue-based return-stack model.
module tb_jump_branch_ras_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jump_branch_ras_if #(.XLEN(32), .RAS_DEPTH(8)) bus ();

`ifdef JUMP_BRANCH_RAS_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_mispredicts;
`endif

  jump_branch_ras_unit #(
    .XLEN(32), .RAS_DEPTH(8), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef JUMP_BRANCH_RAS_PERF_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q [$];
  logic        e_redir, e_len, e_mis;
  logic [31:0] e_addr, e_laddr;
  logic [4:0]  e_lreg;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rsi, input logic [4:0] rdi,
                       input logic [31:0] p, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [25:0] jt,
                       input logic [15:0] im);
    logic [31:0] pc4;
    shortint si;
    bit jr, jalr;
    pc4 = p + 32'd4;
    si = im;
    jr = (op == 0) && (fn == 8);
    jalr = (op == 0) && (fn == 9);
    e_redir = 0; e_addr = pc4; e_len = 0;
    e_lreg = 0; e_laddr = pc4; e_mis = 0;
    if (op == 2 || op == 3) begin
      e_redir = 1;
      e_addr = (pc4 & 32'hF000_0000) | (32'(jt) << 2);
    end
    if (jr || jalr) begin
      e_redir = 1;
      e_addr = rs;
    end
    if ((op == 4 && rs == rt) || (op == 5 && rs != rt)) begin
      e_redir = 1;
      e_addr = pc4 + 32'(int'(si) * 4);
    end
    if (op == 3) begin e_len = 1; e_lreg = 31; end
    if (jalr) begin e_len = 1; e_lreg = rdi; end
    if (jr && rsi == 31) begin
      if (q.size() == 0) e_mis = 1;
      else begin
        e_mis = q[$] != rs;
        void'(q.pop_back());
      end
    end else if (jalr && rsi == 31 && rdi == 31) begin
      if (q.size() == 0) begin
        e_mis = 1;
        q.push_back(pc4);
      end else begin
        e_mis = q[$] != rs;
        q[$] = pc4;
      end
    end else if (op == 3 || (jalr && rdi == 31)) begin
      q.push_back(pc4);
      if (q.size() > 8) void'(q.pop_front());
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rsi, input logic [4:0] rdi,
                       input logic [31:0] p, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [25:0] jt,
                       input logic [15:0] im);
    bus.opcode = op; bus.funct = fn;
    bus.rs_idx = rsi; bus.rd_idx = rdi;
    bus.pc = p; bus.rs_data = rs; bus.rt_data = rt;
    bus.jump_target = jt; bus.imm16 = im;
    bus.in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".redir"}, 32'(bus.redirect), 32'(e_redir));
    chk({tag, ".addr"}, bus.redirect_addr, e_addr);
    chk({tag, ".len"}, 32'(bus.link_enable), 32'(e_len));
    chk({tag, ".lreg"}, 32'(bus.link_reg), 32'(e_lreg));
    chk({tag, ".laddr"}, bus.link_address, e_laddr);
    chk({tag, ".mis"}, 32'(bus.ras_mispredict), 32'(e_mis));
    chk({tag, ".depth"}, 32'(bus.ras_depth), 32'(q.size()));
  endtask

  task automatic send(input string tag,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rsi, input logic [4:0] rdi,
                      input logic [31:0] p, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [25:0] jt,
                      input logic [15:0] im);
    drive(op, fn, rsi, rdi, p, rs, rt, jt, im);
    bus.out_ready = 1'b1;
    model(op, fn, rsi, rdi, p, rs, rt, jt, im);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    logic [31:0] a_addr, a_laddr, r_pc, r_rs, r_rt;
    logic [5:0]  r_op, r_fn;
    logic [4:0]  r_rsi, r_rdi;
    int d0;

    bus.in_valid = 0; bus.out_ready = 1;
    bus.pc = 0; bus.opcode = 0; bus.funct = 0;
    bus.rs_idx = 0; bus.rd_idx = 0;
    bus.rs_data = 0; bus.rt_data = 0;
    bus.jump_target = 0; bus.imm16 = 0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.valid", 32'(bus.out_valid), 0);
    chk("rst.ready", 32'(bus.in_ready), 1);
    chk("rst.depth", 32'(bus.ras_depth), 0);
    chk("rst.redir", 32'(bus.redirect), 0);
    chk("rst.addr", bus.redirect_addr, 0);
    chk("rst.len", 32'(bus.link_enable), 0);
    chk("rst.lreg", 32'(bus.link_reg), 0);
    chk("rst.laddr", bus.link_address, 0);
    chk("rst.mis", 32'(bus.ras_mispredict), 0);

    // 2: jal
    send("jal", 6'h03, 0, 0, 0, 32'h0040_0010, 0, 0, 26'h010_0000, 0);
    chk("jal.addr_k", bus.redirect_addr, 32'h0040_0000);
    chk("jal.laddr_k", bus.link_address, 32'h0040_0014);
    chk("jal.lreg_k", 32'(bus.link_reg), 31);
    chk("jal.depth_k", 32'(bus.ras_depth), 1);

    // 3: return hits, then empty return mispredicts
    send("jr1", 6'h00, 6'h08, 31, 0, 32'h0050_0000, 32'h0040_0014, 0, 0, 0);
    chk("jr1.mis_k", 32'(bus.ras_mispredict), 0);
    chk("jr1.depth_k", 32'(bus.ras_depth), 0);
    send("jr2", 6'h00, 6'h08, 31, 0, 32'h0050_0000, 32'h0040_0014, 0, 0, 0);
    chk("jr2.mis_k", 32'(bus.ras_mispredict), 1);
    chk("jr2.depth_k", 32'(bus.ras_depth), 0);

    // 4: beq taken backwards and not taken
    send("beq_t", 6'h04, 0, 0, 0, 32'h100, 5, 5, 0, 16'hFFFE);
    chk("beq_t.addr_k", bus.redirect_addr, 32'h0FC);
    send("beq_n", 6'h04, 0, 0, 0, 32'h100, 5, 6, 0, 16'hFFFE);
    chk("beq_n.redir_k", 32'(bus.redirect), 0);
    chk("beq_n.addr_k", bus.redirect_addr, 32'h104);
    send("bne_t", 6'h05, 0, 0, 0, 32'hFFFF_FFF8, 1, 2, 0, 16'h0001);
    send("jalr", 6'h00, 6'h09, 3, 7, 32'h200, 32'h1234, 0, 0, 0);
    send("other", 6'h23, 0, 31, 31, 32'h300, 32'h1, 0, 26'h3, 16'h5);

    // 5: overflow the stack
    for (int i = 0; i < 9; i++)
      send("fill", 6'h03, 0, 0, 0, 32'h1000 + 32'(i) * 16,
           0, 0, 26'(i), 0);
    chk("fill.depth_k", 32'(bus.ras_depth), 8);
    for (int i = 8; i >= 1; i--) begin
      send("ret", 6'h00, 6'h08, 31, 0, 32'h2000,
           32'h1004 + 32'(i) * 16, 0, 0, 0);
      chk("ret.mis_k", 32'(bus.ras_mispredict), 0);
    end
    send("ret9", 6'h00, 6'h08, 31, 0, 32'h2000, 32'h1004, 0, 0, 0);
    chk("ret9.mis_k", 32'(bus.ras_mispredict), 1);

    // drain, then 6: backpressure
    @(posedge clk); #1;
    chk("drain.valid", 32'(bus.out_valid), 0);
    d0 = q.size();
    drive(6'h03, 0, 0, 0, 32'h4000, 0, 0, 26'h111, 0);
    bus.out_ready = 1'b0;
    model(6'h03, 0, 0, 0, 32'h4000, 0, 0, 26'h111, 0);
    @(posedge clk); #1;
    check_out("bp0");
    a_addr = e_addr; a_laddr = e_laddr;
    drive(6'h03, 0, 0, 0, 32'h5000, 0, 0, 26'h222, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.ready", 32'(bus.in_ready), 0);
      chk("bp.addr", bus.redirect_addr, a_addr);
      chk("bp.laddr", bus.link_address, a_laddr);
      chk("bp.depth", 32'(bus.ras_depth), 32'(d0 + 1));
    end
    bus.out_ready = 1'b1;
    model(6'h03, 0, 0, 0, 32'h5000, 0, 0, 26'h222, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_out("bp1");

    // randomized mix weighted toward stack traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: r_op = 6'h02;
        1: r_op = 6'h03;
        2: r_op = 6'h04;
        3: r_op = 6'h05;
        4, 5, 6: r_op = 6'h00;
        default: r_op = 6'($urandom_range(6, 63));
      endcase
      case ($urandom_range(0, 4))
        0: r_fn = 6'($urandom);
        1, 2: r_fn = 6'h08;
        default: r_fn = 6'h09;
      endcase
      r_rsi = $urandom_range(0, 1) ? 5'd31 : 5'($urandom);
      r_rdi = $urandom_range(0, 1) ? 5'd31 : 5'($urandom);
      r_pc = $urandom & 32'hFFFF_FFFC;
      r_rs = $urandom;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) r_rs = q[$];
      r_rt = $urandom_range(0, 1) ? r_rs : 32'($urandom);
      send("rand", r_op, r_fn, r_rsi, r_rdi, r_pc, r_rs, r_rt,
           26'($urandom), 16'($urandom));
    end

    // reset with a result in flight
    drive(6'h03, 0, 0, 0, 32'h6000, 0, 0, 26'h5, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chk("mrst.valid", 32'(bus.out_valid), 0);
    chk("mrst.ready", 32'(bus.in_ready), 1);
    chk("mrst.depth", 32'(bus.ras_depth), 0);
    chk("mrst.redir", 32'(bus.redirect), 0);
    send("mrst.jr", 6'h00, 6'h08, 31, 0, 32'h7000, 32'h6004, 0, 0, 0);
    chk("mrst.mis_k", 32'(bus.ras_mispredict), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
